// File: rtl/mouse_pos_tracker.sv
// Purpose : assemble PS/2 mouse packets and track an absolute, screen-clamped cursor.
// Latency : outputs and pos_valid update 1 cycle after the rx_valid of the final packet byte.
// Backpres: none; every byte offered on rx_valid is consumed in its own cycle.
//
// Ports
//   clk100MHz          100 MHz system clock
//   rst                synchronous, active-high reset
//   rx_data/rx_valid   byte strobe from the PS/2 receiver
//   rx_err             receiver parity/framing error strobe; drops any partial packet
//   xpos/ypos          cursor position, 0..X_MAX / 0..Y_MAX, Y grows downwards
//   left/right/middle  button states from the last complete packet
//   wheel              signed wheel delta of the last packet (0 unless MOUSE_WHEEL_EN)
//   pos_valid          one-cycle strobe, outputs were just updated
//
// Build option: define MOUSE_WHEEL_EN for 4-byte IntelliMouse packets
// (extra wheel byte). Without it, packets are the standard 3 bytes and
// wheel is tied to zero. The port list is the same in both builds.

module mouse_pos_tracker #(
    parameter int X_MAX          = 1279,
    parameter int Y_MAX          = 719,
    parameter int X_INIT         = 640,
    parameter int Y_INIT         = 360,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic        clk100MHz,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_err,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        left,
    output logic        right,
    output logic        middle,
    output logic [3:0]  wheel,
    output logic        pos_valid
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic signed [13:0] X_MAX_S = 14'(X_MAX);
    localparam logic signed [13:0] Y_MAX_S = 14'(Y_MAX);

    // Byte-position states of the packet assembler.
    localparam logic [1:0] ST_B0 = 2'd0;
    localparam logic [1:0] ST_B1 = 2'd1;
    localparam logic [1:0] ST_B2 = 2'd2;
`ifdef MOUSE_WHEEL_EN
    localparam logic [1:0] ST_B3 = 2'd3;
`endif

    logic [1:0]       state;
    logic [CNT_W-1:0] idle_cnt;

    // Header fields kept from byte 0 (bit 3 is only the sync marker).
    logic [2:0]       hdr_btn;
    logic             hdr_xs;
    logic             hdr_ys;
    logic             hdr_xo;
    logic             hdr_yo;
    logic [7:0]       dx_lo;

`ifdef MOUSE_WHEEL_EN
    logic [7:0]       dy_lo;
    logic [3:0]       wheel_q;
`endif

    logic             accept;
    logic             last_byte;
    logic             update;
    logic [7:0]       dy_byte;

    logic signed [8:0]  dx9;
    logic signed [8:0]  dy9;
    logic signed [13:0] nx;
    logic signed [13:0] ny;
    logic [11:0]        x_new;
    logic [11:0]        y_new;

    // A byte counts only without a simultaneous error; in B0 it must also
    // carry the sync bit, so stray bytes never start a packet.
    assign accept = rx_valid && !rx_err && ((state != ST_B0) || rx_data[3]);

`ifdef MOUSE_WHEEL_EN
    assign last_byte = (state == ST_B3);
    assign dy_byte   = dy_lo;
`else
    // In the 3-byte build the Y byte is still on the bus when the update
    // fires, so it is used straight from rx_data instead of being stored.
    assign last_byte = (state == ST_B2);
    assign dy_byte   = rx_data;
`endif

    assign update = accept && last_byte;

    // Delta decode and clamped position update. Everything is done in
    // 14-bit signed so xpos+255 and ypos+256 cannot wrap before clamping.
    always_comb begin
        dx9 = hdr_xo ? 9'sd0 : $signed({hdr_xs, dx_lo});
        dy9 = hdr_yo ? 9'sd0 : $signed({hdr_ys, dy_byte});

        nx = $signed({2'b00, xpos}) + {{5{dx9[8]}}, dx9};
        // PS/2 Y is up-positive, the screen is down-positive.
        ny = $signed({2'b00, ypos}) - {{5{dy9[8]}}, dy9};

        if (nx < 14'sd0) begin
            x_new = 12'd0;
        end else if (nx > X_MAX_S) begin
            x_new = 12'(X_MAX);
        end else begin
            x_new = nx[11:0];
        end

        if (ny < 14'sd0) begin
            y_new = 12'd0;
        end else if (ny > Y_MAX_S) begin
            y_new = 12'(Y_MAX);
        end else begin
            y_new = ny[11:0];
        end
    end

    // Packet assembler and inter-byte timeout. An error always wins; an
    // accepted byte wins over a timeout expiring in the same cycle.
    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            state    <= ST_B0;
            idle_cnt <= '0;
            hdr_btn  <= 3'd0;
            hdr_xs   <= 1'b0;
            hdr_ys   <= 1'b0;
            hdr_xo   <= 1'b0;
            hdr_yo   <= 1'b0;
            dx_lo    <= 8'd0;
`ifdef MOUSE_WHEEL_EN
            dy_lo    <= 8'd0;
`endif
        end else if (rx_err) begin
            state    <= ST_B0;
            idle_cnt <= '0;
        end else if (accept) begin
            idle_cnt <= '0;
            case (state)
                ST_B0: begin
                    hdr_btn <= rx_data[2:0];
                    hdr_xs  <= rx_data[4];
                    hdr_ys  <= rx_data[5];
                    hdr_xo  <= rx_data[6];
                    hdr_yo  <= rx_data[7];
                    state   <= ST_B1;
                end
                ST_B1: begin
                    dx_lo <= rx_data;
                    state <= ST_B2;
                end
`ifdef MOUSE_WHEEL_EN
                ST_B2: begin
                    dy_lo <= rx_data;
                    state <= ST_B3;
                end
`endif
                default: begin
                    // Final byte: the update itself happens in the output block.
                    state <= ST_B0;
                end
            endcase
        end else if (state == ST_B0) begin
            idle_cnt <= '0;
        end else if (idle_cnt == CNT_LAST) begin
            // Partial packet went stale: drop it without updating.
            state    <= ST_B0;
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + CNT_W'(1);
        end
    end

    // Registered outputs; they hold between packets.
    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            xpos      <= 12'(X_INIT);
            ypos      <= 12'(Y_INIT);
            left      <= 1'b0;
            right     <= 1'b0;
            middle    <= 1'b0;
            pos_valid <= 1'b0;
        end else begin
            pos_valid <= update;
            if (update) begin
                xpos   <= x_new;
                ypos   <= y_new;
                left   <= hdr_btn[0];
                right  <= hdr_btn[1];
                middle <= hdr_btn[2];
            end
        end
    end

`ifdef MOUSE_WHEEL_EN
    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            wheel_q <= 4'd0;
        end else if (update) begin
            wheel_q <= rx_data[3:0];
        end
    end

    assign wheel = wheel_q;
`else
    assign wheel = 4'd0;
`endif

endmodule

// File: tb/tb_mouse_pos_tracker.sv
// Bench for mouse_pos_tracker: directed packets with literal expectations,
// then random byte streams; a packet-level model predicts every output cycle.
// The timeout is shortened so stale-packet cases stay cheap to simulate.

module tb_mouse_pos_tracker;

    localparam int T = 64;
`ifdef MOUSE_WHEEL_EN
    localparam int PLEN = 4;
`else
    localparam int PLEN = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_err;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        left;
    logic        right;
    logic        middle;
    logic [3:0]  wheel;
    logic        pos_valid;

    mouse_pos_tracker #(
        .X_MAX(1279), .Y_MAX(719), .X_INIT(640), .Y_INIT(360), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk100MHz(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_err(rx_err),
        .xpos(xpos),
        .ypos(ypos),
        .left(left),
        .right(right),
        .middle(middle),
        .wheel(wheel),
        .pos_valid(pos_valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // ---------------- behavioural model ----------------
    int ex = 640, ey = 360, eb = 0, ew = 0, ev = 0;
    int pkt[$];
    int edge_n = 0;
    int last_acc = 0;

    always @(posedge clk) begin : model
        int hdr, dx, dy, nx, ny;
        edge_n++;
        if (rst) begin
            ex = 640; ey = 360; eb = 0; ew = 0; ev = 0;
            pkt.delete();
        end else begin
            ev = 0;
            // More than T edges since the last byte: partial packet is gone.
            if (pkt.size() > 0 && (edge_n - last_acc) > T) pkt.delete();
            if (rx_err) begin
                pkt.delete();
            end else if (rx_valid) begin
                if (pkt.size() > 0 || rx_data[3]) begin
                    pkt.push_back(int'(rx_data));
                    last_acc = edge_n;
                end
                if (pkt.size() == PLEN) begin
                    hdr = pkt[0];
                    dx = ((hdr >> 6) & 1) ? 0 : pkt[1] - (((hdr >> 4) & 1) ? 256 : 0);
                    dy = ((hdr >> 7) & 1) ? 0 : pkt[2] - (((hdr >> 5) & 1) ? 256 : 0);
                    nx = ex + dx;
                    ny = ey - dy;
                    ex = (nx < 0) ? 0 : (nx > 1279) ? 1279 : nx;
                    ey = (ny < 0) ? 0 : (ny > 719) ? 719 : ny;
                    eb = hdr & 7;
                    if (PLEN == 4) ew = pkt[PLEN-1] & 15;
                    ev = 1;
                    pkt.delete();
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [31:0] got, want;
        if (chk_en) begin
            got  = {xpos, ypos, middle, right, left, wheel, pos_valid};
            want = {12'(ex), 12'(ey), 3'(eb), 4'(ew), 1'(ev)};
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL outputs @edge %0d: got x=%0d y=%0d btn=%b w=%h v=%b, want x=%0d y=%0d btn=%0d w=%0d v=%0d",
                         edge_n, xpos, ypos, {middle, right, left}, wheel, pos_valid,
                         ex, ey, eb, ew, ev);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [7:0] d, input logic v, input logic e, input logic r);
        rx_data = d; rx_valid = v; rx_err = e; rst = r;
        @(negedge clk);
        rx_data = 8'h00; rx_valid = 1'b0; rx_err = 1'b0; rst = 1'b0;
    endtask

    task automatic byte_in(input logic [7:0] d);
        drive(d, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive(8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic pkt3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        byte_in(a); byte_in(b); byte_in(c);
`ifdef MOUSE_WHEEL_EN
        byte_in(8'h00);
`endif
    endtask

    task automatic lit(input string nm, input int act, input int want);
        n_tests++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, want);
        end
    endtask

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_err = 1'b0;
        @(negedge clk);
        do_reset();
        chk_en = 1'b1;

        // Reset state
        lit("reset_x", int'(xpos), 640);
        lit("reset_y", int'(ypos), 360);
        lit("reset_v", int'(pos_valid), 0);

        // Basic +16 move, strobe exactly one cycle
        pkt3(8'h08, 8'h10, 8'h00);
        lit("p1_x_model", ex, 656);
        lit("p1_x", int'(xpos), 656);
        lit("p1_v", int'(pos_valid), 1);
        idle(1);
        lit("p1_v_drop", int'(pos_valid), 0);

        // Negative X, positive Y (moves up), left button
        do_reset();
        pkt3(8'h19, 8'hF0, 8'h05);
        lit("p2_x", int'(xpos), 624);
        lit("p2_y_model", ey, 355);
        lit("p2_y", int'(ypos), 355);
        lit("p2_left", int'(left), 1);

        // Clamp at the right edge
        do_reset();
        pkt3(8'h08, 8'hFF, 8'h00); lit("clx1", int'(xpos), 895);
        pkt3(8'h08, 8'hFF, 8'h00); lit("clx2", int'(xpos), 1150);
        pkt3(8'h08, 8'hFF, 8'h00); lit("clx3", int'(xpos), 1279);
        pkt3(8'h08, 8'hFF, 8'h00); lit("clx4", int'(xpos), 1279);
        // 0x38,0x00,0x80: dx=-256, dy=-128 -> moves left and down, clamp at bottom
        pkt3(8'h38, 8'h00, 8'h80); lit("cly1", int'(ypos), 488); lit("cly1_x", int'(xpos), 1023);
        pkt3(8'h38, 8'h00, 8'h80); lit("cly2", int'(ypos), 616);
        pkt3(8'h38, 8'h00, 8'h80); lit("cly3", int'(ypos), 719);

        // Byte without sync bit is discarded in B0
        do_reset();
        byte_in(8'h00);
        pkt3(8'h08, 8'h01, 8'h00);
        lit("sync_x", int'(xpos), 641);
        // Stale partial dropped after the timeout
        byte_in(8'h08); byte_in(8'h05);
        idle(T + 10);
        lit("stale_v", int'(pos_valid), 0);
        pkt3(8'h08, 8'h02, 8'h00);
        lit("stale_x", int'(xpos), 643);

        // Error and reset aborts
        do_reset();
        byte_in(8'h08);
        drive(8'h00, 1'b0, 1'b1, 1'b0);
        byte_in(8'h08); byte_in(8'h05);
        drive(8'h05, 1'b1, 1'b1, 1'b0);
        byte_in(8'h00);
        byte_in(8'h08);
        do_reset();
        lit("abort_x", int'(xpos), 640);
        lit("abort_y", int'(ypos), 360);
        // X overflow forces dx=0
        pkt3(8'h48, 8'h7F, 8'h03);
        lit("ovf_x", int'(xpos), 640);
        lit("ovf_y", int'(ypos), 357);

        // 4-byte stream
        byte_in(8'h08); byte_in(8'h00); byte_in(8'h00);
`ifdef MOUSE_WHEEL_EN
        lit("wh_v3", int'(pos_valid), 0);
        byte_in(8'h0F);
        lit("wh_v4", int'(pos_valid), 1);
        lit("wh_w", int'(wheel), 15);
`else
        lit("wh_v3", int'(pos_valid), 1);
        byte_in(8'h0F);
        lit("wh_v4", int'(pos_valid), 0);
        lit("wh_w", int'(wheel), 0);
        drive(8'h00, 1'b0, 1'b1, 1'b0);
`endif

        // Random streams
        repeat (2500) begin
            int r;
            logic [7:0] h;
            r = $urandom_range(0, 99);
            if (r < 70) begin
                h = 8'($urandom) | 8'h08;
                if ($urandom_range(0, 3) != 0) h = h & 8'h3F;
                byte_in(h);
                for (int k = 1; k < PLEN; k++) begin
                    idle($urandom_range(0, 2));
                    byte_in(8'($urandom));
                end
            end else if (r < 85) begin
                byte_in(8'($urandom));
            end else if (r < 90) begin
                drive(8'($urandom), 1'($urandom), 1'b1, 1'b0);
            end else if (r < 92) begin
                do_reset();
            end else if (r < 94) begin
                idle(T + 5 + $urandom_range(0, 10));
            end else begin
                idle($urandom_range(1, 3));
            end
        end

        idle(2);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
